hazard_interlock: RTL and testbench
===================================

# hazard_interlock

Pipeline interlock and long-latency scoreboard for the 5-stage RISC-V core. It sits between IF/ID and ID/EX and drives the stall and flush controls that the forwarding path cannot resolve. It detects load-use hazards and taken-branch flushes. It also owns the fixed-latency divider's destination scoreboard: it launches a divide, counts its latency, requests the writeback slot, and holds any dependent instruction in ID until the result is written.

## Interface
Parameters:
- WIDTH_SOURCE, 5, register index width
- DIV_LATENCY, 33, cycles from the Div_Start cycle to the first Div_WB_Req cycle; must be at least 2
- CNT_W, 6, divider counter width; must satisfy 2^CNT_W > DIV_LATENCY

Ports:
- CLK  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- IF_ID_Rs1, IF_ID_Rs2, IF_ID_Rd  in  WIDTH_SOURCE each  decode-stage register indices
- IF_ID_Rs1_Used, IF_ID_Rs2_Used, IF_ID_Reg_Wr  in  1 each  operand-read qualifiers and register-write qualifier for the decode-stage instruction
- IF_ID_Div  in  1  decode-stage instruction is DIV/DIVU/REM/REMU
- ID_EX_Mem_Rd  in  1  instruction in EX is a load
- ID_EX_Div  in  1  instruction in EX is a divide
- ID_EX_Rd  in  WIDTH_SOURCE  EX destination
- Branch_Taken  in  1  EX resolved a taken branch or jump
- Div_WB_Ack  in  1  WB stage grants the write port this cycle
- PC_Write, IF_ID_Write  out  1 each  pipeline advance enables
- IF_ID_Flush, ID_EX_Flush  out  1 each  bubble insertion
- Div_Start  out  1  one-cycle divider launch
- Div_WB_Req  out  1  divider result ready, requesting the write port
- Div_WB_Rd  out  WIDTH_SOURCE  divider destination

## Operation
The FSM has three states, each with its own transitions:
- IDLE: on Div_Start, load cnt = DIV_LATENCY-2, latch pend_rd = ID_EX_Rd, and go to BUSY.
- BUSY: if cnt==0, go to DONE; otherwise decrement cnt.
- DONE: Div_WB_Req=1; on Div_WB_Ack, go to IDLE.

Divider launch and scoreboard:
- Div_Start = ID_EX_Div && state==IDLE && ID_EX_Rd!=0. A divide with rd=x0 is a nop: no start and no scoreboard entry.
- pend_valid = state!=IDLE. Div_WB_Rd = pend_rd, and reads 0 in IDLE.

Stall conditions (combinational):
- load_use: ID_EX_Mem_Rd && ID_EX_Rd!=0 && ((Rs1_Used && ID_EX_Rd==IF_ID_Rs1) || (Rs2_Used && ID_EX_Rd==IF_ID_Rs2)).
- div_raw: pend_valid && a used source equals pend_rd.
- div_waw: pend_valid && IF_ID_Reg_Wr && IF_ID_Rd==pend_rd.
- div_struct: IF_ID_Div && (state!=IDLE || ID_EX_Div).
- A stall is any of these. On a stall: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.

Branch priority:
- Branch_Taken overrides every stall: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1.
- A stalled decode instruction is discarded by the flush.
- The scoreboard and FSM are unaffected, because an in-flight divide is architecturally older than the branch.

Default (no stall, no branch): PC_Write=1, IF_ID_Write=1, both flushes 0.

## Timing
- Reset: state=IDLE, cnt=0, pend_rd=0. Outputs during and after reset: PC_Write=1, IF_ID_Write=1, flushes 0, Div_Start=0, Div_WB_Req=0, Div_WB_Rd=0.
- Reset asserted mid-divide abandons the divide; the result is never written back.
- Div_WB_Req rises exactly DIV_LATENCY cycles after the Div_Start cycle. It holds, with Div_WB_Rd stable, until the Div_WB_Ack cycle inclusive.
- The ack cycle itself still stalls dependents. The register file writes on that edge, and the dependent decodes on the following cycle.
- A new divide can launch no earlier than the cycle after the ack.
- Load-use costs exactly one bubble.
- Stall controls are combinational from inputs and registered state; there is no added latency.

## Structure
- riscv_hazard_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - WIDTH_SOURCE;
  - the x0 index constant.
- Sub-module div_scoreboard contains the FSM, counter, and pend_rd, and exports pend_valid, pend_rd, and Div_WB_Req.
- The top level contains the combinational stall and flush logic.

## Test plan
- Load into x5 in EX, decode reads x5 via Rs2 -> one cycle with PC_Write=0 and ID_EX_Flush=1. Same stimulus with ID_EX_Rd=0, or with Rs2_Used=0 -> no stall.
- DIV into x7 with DIV_LATENCY=33 -> Div_Start one cycle, then Div_WB_Req rises 33 cycles later. An independent ADD x8 flows with no stall; ADD x9,x7,x1 stalls until the cycle after the ack.
- Div_WB_Ack held low for 4 cycles in DONE -> Div_WB_Req and Div_WB_Rd=7 stable, and the dependent stays stalled. Ack -> IDLE next cycle.
- Back-to-back DIVs, ID_EX_Div=1 and IF_ID_Div=1 -> second DIV held in ID through BUSY and DONE, then its Div_Start fires two cycles after the first ack.
- Branch_Taken coincides with a load-use stall and a pending divide -> all four controls show the flush pattern, and the divide still completes and requests writeback.
- rst_n pulled low while in BUSY with cnt=10 -> immediate IDLE and Div_WB_Req=0. After release, a dependent of the old rd decodes without stalling.

Source files
------------

// File: rtl/hazard_interlock_pkg.sv
// Shared types and constants for the pipeline interlock and divider scoreboard.
package riscv_hazard_pkg;

    localparam int WIDTH_SOURCE = 5;

    localparam logic [WIDTH_SOURCE-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // One bit per independent reason the decode-stage instruction must wait.
    typedef struct packed {
        logic load_use;
        logic div_raw;
        logic div_waw;
        logic div_struct;
    } stall_cause_t;

endpackage

// File: rtl/hazard_interlock_div_scoreboard.sv
// Fixed-latency divider tracker: counts the divide latency, holds the destination
// register and requests the writeback port until it is granted.
//
// state | meaning
// IDLE  | no divide in flight; pend_rd is not meaningful
// BUSY  | divide in flight, cnt counting down to the result cycle
// DONE  | result ready, div_wb_req held until div_wb_ack
module div_scoreboard #(
    parameter int WIDTH_SOURCE = riscv_hazard_pkg::WIDTH_SOURCE,
    parameter int DIV_LATENCY  = 33,
    parameter int CNT_W        = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    div_start,
    input  logic [WIDTH_SOURCE-1:0] div_rd,
    input  logic                    div_wb_ack,
    output logic                    pend_valid,
    output logic [WIDTH_SOURCE-1:0] pend_rd,
    output logic                    div_wb_req
);
    import riscv_hazard_pkg::*;

    // BUSY spends CNT_LOAD+1 cycles, so DONE is reached DIV_LATENCY cycles after the start cycle.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 2);

    div_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH_SOURCE-1:0] rd_q, rd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (div_start) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    rd_d    = div_rd;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (div_wb_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pend_valid = (state_q != IDLE);
    assign div_wb_req = (state_q == DONE);
    assign pend_rd    = rd_q;

endmodule

// File: rtl/hazard_interlock.sv
// Decode-stage interlock: load-use and divider hazards stall ID, a taken branch
// flushes IF/ID and ID/EX regardless of any stall.
module hazard_interlock #(
    parameter int WIDTH_SOURCE = riscv_hazard_pkg::WIDTH_SOURCE,
    parameter int DIV_LATENCY  = 33,
    parameter int CNT_W        = 6
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic [WIDTH_SOURCE-1:0] IF_ID_Rs1,
    input  logic [WIDTH_SOURCE-1:0] IF_ID_Rs2,
    input  logic [WIDTH_SOURCE-1:0] IF_ID_Rd,
    input  logic                    IF_ID_Rs1_Used,
    input  logic                    IF_ID_Rs2_Used,
    input  logic                    IF_ID_Reg_Wr,
    input  logic                    IF_ID_Div,
    input  logic                    ID_EX_Mem_Rd,
    input  logic                    ID_EX_Div,
    input  logic [WIDTH_SOURCE-1:0] ID_EX_Rd,
    input  logic                    Branch_Taken,
    input  logic                    Div_WB_Ack,
    output logic                    PC_Write,
    output logic                    IF_ID_Write,
    output logic                    IF_ID_Flush,
    output logic                    ID_EX_Flush,
    output logic                    Div_Start,
    output logic                    Div_WB_Req,
    output logic [WIDTH_SOURCE-1:0] Div_WB_Rd
);
    import riscv_hazard_pkg::*;

    localparam logic [WIDTH_SOURCE-1:0] X0 = WIDTH_SOURCE'(REG_X0);

    logic                    pend_valid;
    logic [WIDTH_SOURCE-1:0] pend_rd;
    logic                    ex_rd_nonzero;
    logic                    stall;
    stall_cause_t            cause;

    assign ex_rd_nonzero = (ID_EX_Rd != X0);

    // A divide targeting x0 has no architectural effect and is never tracked.
    assign Div_Start = ID_EX_Div && !pend_valid && ex_rd_nonzero;

    div_scoreboard #(
        .WIDTH_SOURCE (WIDTH_SOURCE),
        .DIV_LATENCY  (DIV_LATENCY),
        .CNT_W        (CNT_W)
    ) u_div_scoreboard (
        .clk        (CLK),
        .rst_n      (rst_n),
        .div_start  (Div_Start),
        .div_rd     (ID_EX_Rd),
        .div_wb_ack (Div_WB_Ack),
        .pend_valid (pend_valid),
        .pend_rd    (pend_rd),
        .div_wb_req (Div_WB_Req)
    );

    assign Div_WB_Rd = pend_valid ? pend_rd : X0;

    always_comb begin
        cause.load_use   = ID_EX_Mem_Rd && ex_rd_nonzero &&
                           ((IF_ID_Rs1_Used && (IF_ID_Rs1 == ID_EX_Rd)) ||
                            (IF_ID_Rs2_Used && (IF_ID_Rs2 == ID_EX_Rd)));
        cause.div_raw    = pend_valid &&
                           ((IF_ID_Rs1_Used && (IF_ID_Rs1 == pend_rd)) ||
                            (IF_ID_Rs2_Used && (IF_ID_Rs2 == pend_rd)));
        cause.div_waw    = pend_valid && IF_ID_Reg_Wr && (IF_ID_Rd == pend_rd);
        cause.div_struct = IF_ID_Div && (pend_valid || ID_EX_Div);
    end

    assign stall = |cause;

    // The branch is younger than any in-flight divide, so it only touches the pipeline controls.
    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        if (Branch_Taken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (stall) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_interlock.sv
// Randomized and directed bench for hazard_interlock against an age-based divider model.
module tb_hazard_interlock;

    localparam int W       = 5;
    localparam int DIV_LAT = 33;

    logic         CLK = 1'b0;
    logic         rst_n;
    logic [W-1:0] IF_ID_Rs1, IF_ID_Rs2, IF_ID_Rd, ID_EX_Rd;
    logic         IF_ID_Rs1_Used, IF_ID_Rs2_Used, IF_ID_Reg_Wr, IF_ID_Div;
    logic         ID_EX_Mem_Rd, ID_EX_Div, Branch_Taken, Div_WB_Ack;
    logic         PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
    logic         Div_Start, Div_WB_Req;
    logic [W-1:0] Div_WB_Rd;

    int total = 0;
    int bad   = 0;

    hazard_interlock #(.WIDTH_SOURCE(W), .DIV_LATENCY(DIV_LAT), .CNT_W(6)) dut (
        .CLK            (CLK),
        .rst_n          (rst_n),
        .IF_ID_Rs1      (IF_ID_Rs1),
        .IF_ID_Rs2      (IF_ID_Rs2),
        .IF_ID_Rd       (IF_ID_Rd),
        .IF_ID_Rs1_Used (IF_ID_Rs1_Used),
        .IF_ID_Rs2_Used (IF_ID_Rs2_Used),
        .IF_ID_Reg_Wr   (IF_ID_Reg_Wr),
        .IF_ID_Div      (IF_ID_Div),
        .ID_EX_Mem_Rd   (ID_EX_Mem_Rd),
        .ID_EX_Div      (ID_EX_Div),
        .ID_EX_Rd       (ID_EX_Rd),
        .Branch_Taken   (Branch_Taken),
        .Div_WB_Ack     (Div_WB_Ack),
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Flush    (ID_EX_Flush),
        .Div_Start      (Div_Start),
        .Div_WB_Req     (Div_WB_Req),
        .Div_WB_Rd      (Div_WB_Rd)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a divide is pending from the cycle after its launch; its result is ready
    // once DIV_LAT cycles have passed since the launch cycle.
    bit         m_pend = 1'b0;
    logic [W-1:0] m_rd = '0;
    int         m_age  = 0;

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_rd   <= '0;
            m_age  <= 0;
        end else if (m_pend) begin
            if (m_age >= DIV_LAT && Div_WB_Ack) m_pend <= 1'b0;
            m_age <= m_age + 1;
        end else if (ID_EX_Div && ID_EX_Rd != 0) begin
            m_pend <= 1'b1;
            m_rd   <= ID_EX_Rd;
            m_age  <= 1;
        end
    end

    always @(negedge CLK) begin
        bit e_req, e_start, lu, raw, waw, st, stl;
        bit e_pcw, e_ifw, e_iff, e_exf;
        e_req   = m_pend && (m_age >= DIV_LAT);
        e_start = ID_EX_Div && !m_pend && (ID_EX_Rd != 0);
        lu  = ID_EX_Mem_Rd && (ID_EX_Rd != 0) &&
              ((IF_ID_Rs1_Used && IF_ID_Rs1 == ID_EX_Rd) || (IF_ID_Rs2_Used && IF_ID_Rs2 == ID_EX_Rd));
        raw = m_pend && ((IF_ID_Rs1_Used && IF_ID_Rs1 == m_rd) || (IF_ID_Rs2_Used && IF_ID_Rs2 == m_rd));
        waw = m_pend && IF_ID_Reg_Wr && (IF_ID_Rd == m_rd);
        st  = IF_ID_Div && (m_pend || ID_EX_Div);
        stl = lu || raw || waw || st;
        if (Branch_Taken) begin
            e_pcw = 1; e_ifw = 1; e_iff = 1; e_exf = 1;
        end else if (stl) begin
            e_pcw = 0; e_ifw = 0; e_iff = 0; e_exf = 1;
        end else begin
            e_pcw = 1; e_ifw = 1; e_iff = 0; e_exf = 0;
        end
        chk("m_pc_write", 32'(PC_Write), 32'(e_pcw));
        chk("m_if_id_write", 32'(IF_ID_Write), 32'(e_ifw));
        chk("m_if_id_flush", 32'(IF_ID_Flush), 32'(e_iff));
        chk("m_id_ex_flush", 32'(ID_EX_Flush), 32'(e_exf));
        chk("m_div_start", 32'(Div_Start), 32'(e_start));
        chk("m_div_wb_req", 32'(Div_WB_Req), 32'(e_req));
        chk("m_div_wb_rd", 32'(Div_WB_Rd), m_pend ? 32'(m_rd) : 32'd0);
    end

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle();
        IF_ID_Rs1 = '0; IF_ID_Rs2 = '0; IF_ID_Rd = '0; ID_EX_Rd = '0;
        IF_ID_Rs1_Used = 0; IF_ID_Rs2_Used = 0; IF_ID_Reg_Wr = 0; IF_ID_Div = 0;
        ID_EX_Mem_Rd = 0; ID_EX_Div = 0; Branch_Taken = 0; Div_WB_Ack = 0;
    endtask

    task automatic add_instr(input logic [W-1:0] rd, input logic [W-1:0] rs1, input logic [W-1:0] rs2);
        IF_ID_Rd = rd; IF_ID_Rs1 = rs1; IF_ID_Rs2 = rs2;
        IF_ID_Rs1_Used = 1; IF_ID_Rs2_Used = 1; IF_ID_Reg_Wr = 1;
    endtask

    initial begin
        int i;
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_pc_write", 32'(PC_Write), 1);
        chk("rst_if_id_write", 32'(IF_ID_Write), 1);
        chk("rst_flushes", 32'({IF_ID_Flush, ID_EX_Flush}), 0);
        chk("rst_div_req", 32'(Div_WB_Req), 0);
        chk("rst_div_rd", 32'(Div_WB_Rd), 0);
        next(); rst_n = 1'b1;

        // load-use on x5 through Rs2
        next(); set_idle(); ID_EX_Mem_Rd = 1; ID_EX_Rd = 5; add_instr(6, 1, 5);
        @(negedge CLK);
        chk("lu_pc_write", 32'(PC_Write), 0);
        chk("lu_if_id_write", 32'(IF_ID_Write), 0);
        chk("lu_id_ex_flush", 32'(ID_EX_Flush), 1);
        chk("lu_if_id_flush", 32'(IF_ID_Flush), 0);
        next(); ID_EX_Mem_Rd = 0; ID_EX_Rd = 0;
        @(negedge CLK); chk("lu_one_bubble", 32'(PC_Write), 1);
        next(); ID_EX_Mem_Rd = 1; ID_EX_Rd = 0; IF_ID_Rs2 = 0;
        @(negedge CLK); chk("lu_x0", 32'(PC_Write), 1);
        next(); ID_EX_Rd = 5; IF_ID_Rs2 = 5; IF_ID_Rs2_Used = 0;
        @(negedge CLK); chk("lu_rs2_unused", 32'(PC_Write), 1);

        // DIV x7, independent and dependent ADDs, delayed ack
        next(); set_idle(); ID_EX_Div = 1; ID_EX_Rd = 7;
        @(negedge CLK); chk("div7_start", 32'(Div_Start), 1);
        for (i = 1; i <= 37; i++) begin
            next(); set_idle();
            if (i == 3) add_instr(8, 1, 2); else add_instr(9, 7, 1);
            @(negedge CLK);
            chk($sformatf("div7_req_c%0d", i), 32'(Div_WB_Req), (i >= DIV_LAT) ? 1 : 0);
            chk($sformatf("div7_pcw_c%0d", i), 32'(PC_Write), (i == 3) ? 1 : 0);
            if (i >= DIV_LAT) chk("div7_rd_hold", 32'(Div_WB_Rd), 7);
        end
        next(); Div_WB_Ack = 1;
        @(negedge CLK);
        chk("div7_ack_req", 32'(Div_WB_Req), 1);
        chk("div7_ack_stall", 32'(PC_Write), 0);
        next(); Div_WB_Ack = 0;
        @(negedge CLK);
        chk("div7_after_pcw", 32'(PC_Write), 1);
        chk("div7_after_req", 32'(Div_WB_Req), 0);
        chk("div7_after_rd", 32'(Div_WB_Rd), 0);

        // back-to-back divides
        next(); set_idle(); ID_EX_Div = 1; ID_EX_Rd = 3; IF_ID_Div = 1; add_instr(4, 1, 2);
        @(negedge CLK);
        chk("b2b_start1", 32'(Div_Start), 1);
        chk("b2b_struct", 32'(PC_Write), 0);
        for (i = 1; i <= DIV_LAT; i++) begin
            next(); ID_EX_Div = 0; ID_EX_Rd = 0;
            @(negedge CLK);
            chk($sformatf("b2b_hold_c%0d", i), 32'(PC_Write), 0);
        end
        chk("b2b_req", 32'(Div_WB_Req), 1);
        next(); Div_WB_Ack = 1;
        @(negedge CLK); chk("b2b_ack_stall", 32'(PC_Write), 0);
        next(); Div_WB_Ack = 0;
        @(negedge CLK); chk("b2b_decode", 32'(PC_Write), 1);
        next(); set_idle(); ID_EX_Div = 1; ID_EX_Rd = 4;
        @(negedge CLK); chk("b2b_start2", 32'(Div_Start), 1);

        // branch over load-use and pending divide x4
        next(); set_idle(); Branch_Taken = 1; ID_EX_Mem_Rd = 1; ID_EX_Rd = 5; add_instr(9, 5, 4);
        @(negedge CLK);
        chk("br_flush_pattern", 32'({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush}), 32'hF);
        for (i = 2; i <= 60; i++) begin
            next(); set_idle();
            @(negedge CLK);
            if (Div_WB_Req) break;
        end
        chk("br_div_latency", 32'(i), DIV_LAT);
        chk("br_div_rd", 32'(Div_WB_Rd), 4);
        next(); Div_WB_Ack = 1;
        next(); set_idle();

        // reset while BUSY with cnt=10
        next(); ID_EX_Div = 1; ID_EX_Rd = 6;
        @(negedge CLK); chk("rst_mid_start", 32'(Div_Start), 1);
        for (i = 1; i < 22; i++) begin
            next(); set_idle();
        end
        next(); rst_n = 1'b0; add_instr(10, 6, 1);
        @(negedge CLK);
        chk("rst_mid_req", 32'(Div_WB_Req), 0);
        chk("rst_mid_rd", 32'(Div_WB_Rd), 0);
        next(); rst_n = 1'b1;
        @(negedge CLK); chk("rst_mid_dep_free", 32'(PC_Write), 1);
        for (i = 0; i < 15; i++) begin
            next(); set_idle();
            @(negedge CLK);
            chk("rst_mid_no_wb", 32'(Div_WB_Req), 0);
        end

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            next();
            rst_n          = ($urandom_range(0, 599) != 0);
            IF_ID_Rs1      = W'($urandom_range(0, 3));
            IF_ID_Rs2      = W'($urandom_range(0, 3));
            IF_ID_Rd       = W'($urandom_range(0, 3));
            ID_EX_Rd       = W'($urandom_range(0, 3));
            IF_ID_Rs1_Used = 1'($urandom_range(0, 1));
            IF_ID_Rs2_Used = 1'($urandom_range(0, 1));
            IF_ID_Reg_Wr   = ($urandom_range(0, 3) == 0);
            IF_ID_Div      = ($urandom_range(0, 5) == 0);
            ID_EX_Mem_Rd   = ($urandom_range(0, 3) == 0);
            ID_EX_Div      = ($urandom_range(0, 9) == 0);
            Branch_Taken   = ($urandom_range(0, 7) == 0);
            Div_WB_Ack     = ($urandom_range(0, 2) == 0);
        end
        next(); set_idle(); rst_n = 1'b1;
        @(negedge CLK);
        @(posedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
